// File: rtl/vga_timing_gen.sv
// Raster timing generator for 1024x768@60 (XGA). It produces registered pixel and
// line counters, sync and blanking flags, and line/frame start strobes on one clock edge.
module vga_timing_gen #(
  parameter int   H_ACTIVE     = 1024,
  parameter int   H_SYNC_START = 1048,
  parameter int   H_SYNC_END   = 1184,
  parameter int   H_TOTAL      = 1344,
  parameter int   V_ACTIVE     = 768,
  parameter int   V_SYNC_START = 771,
  parameter int   V_SYNC_END   = 777,
  parameter int   V_TOTAL      = 806,
  parameter logic HSYNC_POL    = 1'b0,
  parameter logic VSYNC_POL    = 1'b0
) (
  input  logic        pclk,
  input  logic        rst_n,
  output logic [11:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        line_start,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Thresholds are widened to 13 bits so that an end value of 4096 still compares correctly.
  localparam logic [12:0] H_ACT13 = 13'(H_ACTIVE);
  localparam logic [12:0] H_SS13  = 13'(H_SYNC_START);
  localparam logic [12:0] H_SE13  = 13'(H_SYNC_END);
  localparam logic [12:0] V_ACT13 = 13'(V_ACTIVE);
  localparam logic [12:0] V_SS13  = 13'(V_SYNC_START);
  localparam logic [12:0] V_SE13  = 13'(V_SYNC_END);

  if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
        H_SYNC_END <= H_TOTAL && H_TOTAL <= 4096)) begin : gen_h_cfg_error
    $error("vga_timing_gen: horizontal timing parameters are out of order");
  end

  if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
        V_SYNC_END <= V_TOTAL && V_TOTAL <= 4096)) begin : gen_v_cfg_error
    $error("vga_timing_gen: vertical timing parameters are out of order");
  end

  logic [11:0] hCount_q, hCount_d;
  logic [11:0] vCount_q, vCount_d;
  logic        hSync_q, hSync_d;
  logic        hBlnk_q, hBlnk_d;
  logic        vSync_q, vSync_d;
  logic        vBlnk_q, vBlnk_d;
  logic        lineStart_q, lineStart_d;
  logic        frameStart_q, frameStart_d;
  logic        hWrap, vWrap;

  // Flags are decoded from the next-state counts so that they land on the same edge as the counts.
  always_comb begin
    hWrap    = (hCount_q == H_LAST);
    vWrap    = (vCount_q == V_LAST);
    hCount_d = hWrap ? 12'd0 : hCount_q + 12'd1;
    vCount_d = vCount_q;
    if (hWrap) begin
      vCount_d = vWrap ? 12'd0 : vCount_q + 12'd1;
    end
    hBlnk_d      = ({1'b0, hCount_d} >= H_ACT13);
    hSync_d      = (({1'b0, hCount_d} >= H_SS13) && ({1'b0, hCount_d} < H_SE13)) ?
                   HSYNC_POL : ~HSYNC_POL;
    vBlnk_d      = ({1'b0, vCount_d} >= V_ACT13);
    vSync_d      = (({1'b0, vCount_d} >= V_SS13) && ({1'b0, vCount_d} < V_SE13)) ?
                   VSYNC_POL : ~VSYNC_POL;
    lineStart_d  = hWrap;
    frameStart_d = hWrap && vWrap;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hCount_q     <= 12'd0;
      vCount_q     <= 12'd0;
      hSync_q      <= ~HSYNC_POL;
      hBlnk_q      <= 1'b0;
      vSync_q      <= ~VSYNC_POL;
      vBlnk_q      <= 1'b0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      hSync_q      <= hSync_d;
      hBlnk_q      <= hBlnk_d;
      vSync_q      <= vSync_d;
      vBlnk_q      <= vBlnk_d;
      lineStart_q  <= lineStart_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign hcount_out  = hCount_q;
  assign hsync_out   = hSync_q;
  assign hblnk_out   = hBlnk_q;
  assign vcount_out  = vCount_q;
  assign vsync_out   = vSync_q;
  assign vblnk_out   = vBlnk_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. It compares a default XGA instance and two small-raster
// instances of opposite sync polarity with a model based on elapsed pixel count.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] h;
    logic        hs;
    logic        hb;
    logic [11:0] v;
    logic        vs;
    logic        vb;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef struct packed {
    int   ha, hss, hse, ht, va, vss, vse, vt;
    logic hpol, vpol;
  } cfg_t;

  typedef struct {
    int   k;
    obs_t exp;
  } vec_t;

  localparam cfg_t CFG_DEF = '{ha: 1024, hss: 1048, hse: 1184, ht: 1344,
                               va: 768, vss: 771, vse: 777, vt: 806, hpol: 1'b0, vpol: 1'b0};
  localparam cfg_t CFG_S   = '{ha: 16, hss: 18, hse: 22, ht: 26,
                               va: 6, vss: 7, vse: 9, vt: 11, hpol: 1'b0, vpol: 1'b0};
  localparam cfg_t CFG_SI  = '{ha: 16, hss: 18, hse: 22, ht: 26,
                               va: 6, vss: 7, vse: 9, vt: 11, hpol: 1'b1, vpol: 1'b1};
  localparam int FRAME_S = 26 * 11;

  logic pclk = 1'b0;
  logic rstDef = 1'b0;
  logic rstS = 1'b0;
  int   checks = 0;
  int   failures = 0;
  longint nDef = 0;
  longint nS = 0;

  logic [11:0] hD, vD, hS, vS, hI, vI;
  logic hsD, hbD, vsD, vbD, lsD, fsD;
  logic hsS, hbS, vsS, vbS, lsS, fsS;
  logic hsI, hbI, vsI, vbI, lsI, fsI;
  obs_t obsDef, obsS, obsI;

  always #5 pclk = ~pclk;

  vga_timing_gen dutDef (
    .pclk(pclk), .rst_n(rstDef),
    .hcount_out(hD), .hsync_out(hsD), .hblnk_out(hbD),
    .vcount_out(vD), .vsync_out(vsD), .vblnk_out(vbD),
    .line_start(lsD), .frame_start(fsD)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_END(22), .H_TOTAL(26),
    .V_ACTIVE(6), .V_SYNC_START(7), .V_SYNC_END(9), .V_TOTAL(11)
  ) dutS (
    .pclk(pclk), .rst_n(rstS),
    .hcount_out(hS), .hsync_out(hsS), .hblnk_out(hbS),
    .vcount_out(vS), .vsync_out(vsS), .vblnk_out(vbS),
    .line_start(lsS), .frame_start(fsS)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_END(22), .H_TOTAL(26),
    .V_ACTIVE(6), .V_SYNC_START(7), .V_SYNC_END(9), .V_TOTAL(11),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dutI (
    .pclk(pclk), .rst_n(rstS),
    .hcount_out(hI), .hsync_out(hsI), .hblnk_out(hbI),
    .vcount_out(vI), .vsync_out(vsI), .vblnk_out(vbI),
    .line_start(lsI), .frame_start(fsI)
  );

  assign obsDef = {hD, hsD, hbD, vD, vsD, vbD, lsD, fsD};
  assign obsS   = {hS, hsS, hbS, vS, vsS, vbS, lsS, fsS};
  assign obsI   = {hI, hsI, hbI, vI, vsI, vbI, lsI, fsI};

  // Elapsed clock edges since reset release; this is the only state the model needs.
  always @(posedge pclk or negedge rstDef) begin
    if (!rstDef) nDef <= 0;
    else         nDef <= nDef + 1;
  end

  always @(posedge pclk or negedge rstS) begin
    if (!rstS) nS <= 0;
    else       nS <= nS + 1;
  end

  // Raster position from the elapsed count: position is n mod line length and line is n div
  // line length mod frame height. At n = 0 the reset values follow.
  function automatic obs_t model(cfg_t c, longint n);
    obs_t   o;
    longint h, v;
    h    = n % c.ht;
    v    = (n / c.ht) % c.vt;
    o.h  = 12'(h);
    o.v  = 12'(v);
    o.hb = (h >= c.ha);
    o.hs = (h >= c.hss && h < c.hse) ? c.hpol : ~c.hpol;
    o.vb = (v >= c.va);
    o.vs = (v >= c.vss && v < c.vse) ? c.vpol : ~c.vpol;
    o.ls = (n > 0) && (h == 0);
    o.fs = o.ls && (v == 0);
    return o;
  endfunction

  function automatic obs_t mk(int h, logic hs, logic hb, int v, logic vs, logic vb,
                              logic ls, logic fs);
    obs_t o;
    o = {12'(h), hs, hb, 12'(v), vs, vb, ls, fs};
    return o;
  endfunction

  task automatic checkOutput(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b ls=%b fs=%b",
               name, act.h, act.v, act.hs, act.hb, act.vs, act.vb, act.ls, act.fs,
               exp.h, exp.v, exp.hs, exp.hb, exp.vs, exp.vb, exp.ls, exp.fs);
    end
  endtask

  task automatic checkValue(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // The small instances are reset, released on a falling edge, and then run for k edges.
  task automatic applyStimulus(int k);
    @(negedge pclk);
    rstS = 1'b0;
    repeat (2) @(negedge pclk);
    rstS = 1'b1;
    repeat (k) @(negedge pclk);
    #1;
  endtask

  vec_t vecs[14];
  obs_t e;
  int   strobeRepeat;
  int   hsLowCnt, hbHighCnt;
  int   fsCnt;
  longint fsAt[$];
  logic prevLs, prevFs;

  initial begin
    // Expected outputs of the small raster, computed by hand (line 26, frame 11 lines).
    vecs[0]  = '{0,   mk(0,  1, 0, 0,  1, 0, 0, 0)};
    vecs[1]  = '{1,   mk(1,  1, 0, 0,  1, 0, 0, 0)};
    vecs[2]  = '{16,  mk(16, 1, 1, 0,  1, 0, 0, 0)};
    vecs[3]  = '{18,  mk(18, 0, 1, 0,  1, 0, 0, 0)};
    vecs[4]  = '{21,  mk(21, 0, 1, 0,  1, 0, 0, 0)};
    vecs[5]  = '{22,  mk(22, 1, 1, 0,  1, 0, 0, 0)};
    vecs[6]  = '{25,  mk(25, 1, 1, 0,  1, 0, 0, 0)};
    vecs[7]  = '{26,  mk(0,  1, 0, 1,  1, 0, 1, 0)};
    vecs[8]  = '{156, mk(0,  1, 0, 6,  1, 1, 1, 0)};
    vecs[9]  = '{182, mk(0,  1, 0, 7,  0, 1, 1, 0)};
    vecs[10] = '{239, mk(5,  1, 0, 9,  1, 1, 0, 0)};
    vecs[11] = '{285, mk(25, 1, 1, 10, 1, 1, 0, 0)};
    vecs[12] = '{286, mk(0,  1, 0, 0,  1, 0, 1, 1)};
    vecs[13] = '{287, mk(1,  1, 0, 0,  1, 0, 0, 0)};

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].k);
      checkOutput($sformatf("vec%0d k=%0d", i, vecs[i].k), obsS, vecs[i].exp);
      e    = vecs[i].exp;
      e.hs = ~e.hs;
      e.vs = ~e.vs;
      checkOutput($sformatf("vec%0d inverted k=%0d", i, vecs[i].k), obsI, e);
    end

    // Default XGA instance: ten cycles in reset, then the first three lines.
    repeat (10) begin
      @(negedge pclk);
      #1 checkOutput("default in reset", obsDef, mk(0, 1, 0, 0, 1, 0, 0, 0));
    end
    @(negedge pclk);
    rstDef = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge pclk);
      checkValue($sformatf("first edges hcount %0d", i), hD, i);
    end
    strobeRepeat = 0;
    hsLowCnt = 0;
    hbHighCnt = 0;
    prevLs = 1'b0;
    prevFs = 1'b0;
    for (int i = 4; i < 3 * 1344 + 4; i++) begin
      @(negedge pclk);
      checkOutput($sformatf("default n=%0d", nDef), obsDef, model(CFG_DEF, nDef));
      if (vD == 12'd1 && !hsD) hsLowCnt++;
      if (vD == 12'd1 && hbD)  hbHighCnt++;
      if ((prevLs && lsD) || (prevFs && fsD)) strobeRepeat++;
      prevLs = lsD;
      prevFs = fsD;
    end
    checkValue("default hsync low cycles per line", hsLowCnt, 136);
    checkValue("default hblnk high cycles per line", hbHighCnt, 320);
    rstDef = 1'b0;

    // Hand sequence: an asynchronous reset in the middle of the frame, at h=10 and v=5.
    applyStimulus(5 * 26 + 10);
    checkOutput("mid-frame position", obsS, mk(10, 1, 0, 5, 1, 0, 0, 0));
    #2 rstS = 1'b0;
    #1 checkOutput("mid-frame async reset", obsS, mk(0, 1, 0, 0, 1, 0, 0, 0));
    checkOutput("mid-frame async reset inverted", obsI, mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge pclk);
    rstS = 1'b1;
    @(negedge pclk);
    checkOutput("restart after mid-frame reset", obsS, mk(1, 1, 0, 0, 1, 0, 0, 0));

    // Three small frames: frame_start must occur once every FRAME_S cycles.
    applyStimulus(0);
    fsCnt = 0;
    fsAt.delete();
    for (int i = 0; i < 3 * FRAME_S; i++) begin
      @(negedge pclk);
      if (fsS) begin
        fsCnt++;
        fsAt.push_back(nS);
      end
    end
    checkValue("frame_start count over 3 frames", fsCnt, 3);
    if (fsAt.size() == 3) begin
      checkValue("first frame_start cycle", fsAt[0], FRAME_S);
      checkValue("frame_start spacing 1", fsAt[1] - fsAt[0], FRAME_S);
      checkValue("frame_start spacing 2", fsAt[2] - fsAt[1], FRAME_S);
    end

    // Random run lengths, each interrupted by an asynchronous reset at a random point in the cycle.
    applyStimulus(0);
    for (int it = 0; it < 16; it++) begin
      int runLen;
      runLen = $urandom_range(20, 2 * FRAME_S + 40);
      for (int c = 0; c < runLen; c++) begin
        @(negedge pclk);
        checkOutput($sformatf("rand it%0d n=%0d", it, nS), obsS, model(CFG_S, nS));
        checkOutput($sformatf("rand inv it%0d n=%0d", it, nS), obsI, model(CFG_SI, nS));
        if ((prevLs && lsS) || (prevFs && fsS)) strobeRepeat++;
        prevLs = lsS;
        prevFs = fsS;
      end
      @(negedge pclk);
      #($urandom_range(1, 3));
      rstS = 1'b0;
      #1 checkOutput($sformatf("rand async reset it%0d", it), obsS, model(CFG_S, 0));
      checkOutput($sformatf("rand async reset inv it%0d", it), obsI, model(CFG_SI, 0));
      repeat ($urandom_range(1, 4)) @(negedge pclk);
      rstS = 1'b1;
      prevLs = 1'b0;
      prevFs = 1'b0;
    end
    checkValue("strobes high on consecutive cycles", strobeRepeat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
